scan_arbiter: RTL and testbench
===============================

# scan_arbiter

Shares one pattern scanner between NREQ dispatcher streams. Grants whole blocks, from first beat through the `end` beat, in round-robin order, and forwards the granted stream to the scanner. It records the source of every forwarded block in an in-order tag FIFO, so the collector can attribute each scanner result to its requester. It sits between the dispatchers and the scanner's `dpt_*` input port, and snoops the scanner-to-collector handshake.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8); GW = max(1, clog2(NREQ))
- DEPTH, 4, tag FIFO depth, power of 2 (2..16)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_dvld  in  NREQ  per-requester beat valid
- req_cmd  in  8*NREQ  command, requester i at [8i+7:8i]
- req_id  in  24*NREQ  block id
- req_poff  in  32*NREQ  packet offset
- req_data  in  256*NREQ  payload
- req_bvld  in  32*NREQ  byte valid
- req_end  in  NREQ  last beat of block
- arb_rdy_req  out  NREQ  ready to requester
- arb_dvld_scn  out  1  beat valid to scanner
- arb_cmd_scn / arb_id_scn / arb_poff_scn / arb_data_scn / arb_bvld_scn / arb_end_scn  out  8/24/32/256/32/1  muxed fields
- scn_rdy_arb  in  1  scanner ready
- scn_dvld_clt  in  1  scanner result valid (snooped)
- scn_end_clt  in  1  scanner result end (snooped)
- clt_rdy_scn  in  1  collector ready (snooped)
- res_src  out  GW  requester index of current scanner result (FIFO head)
- res_src_vld  out  1  tag FIFO non-empty
- blk_cnt  out  32  blocks forwarded, wraps at 2^32
- err_underflow  out  1  sticky: result completed while FIFO empty

## Operation
- Beat transfer: `valid & ready` on a cycle. Result completion: `scn_dvld_clt & scn_end_clt & clt_rdy_scn`.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - Outputs are arb_dvld_scn=0 and arb_rdy_req=0.
  - If any req_dvld bit is set and the FIFO is not full, select the first requester with req_dvld set, searching from (last+1) mod NREQ upward with wrap.
  - Register the choice into gnt and go to BUSY.
  - If the FIFO is full, stay in IDLE.
- BUSY:
  - All arb_*_scn fields are driven from requester gnt.
  - arb_dvld_scn = req_dvld[gnt].
  - arb_rdy_req = one-hot(gnt) & scn_rdy_arb; all other bits are 0.
  - Non-granted requesters are never ready. The grant never changes mid-block.
- End beat transferred in BUSY:
  - Push gnt into the FIFO.
  - last <= gnt.
  - blk_cnt += 1.
  - Go to IDLE.
- FIFO pop: on result completion with the FIFO non-empty. res_src = head entry; res_src is 0 when empty.
- Simultaneous push and pop: both take effect; occupancy is unchanged. The full check in IDLE uses registered occupancy only.
- Result completion with an empty FIFO sets err_underflow. The FIFO is not modified. err_underflow clears only on reset.
- Overflow is impossible: a grant requires a free entry, and each grant pushes at most one entry.

## Timing
- Reset values:
  - arb_dvld_scn=0, arb_rdy_req=0, all arb_*_scn fields 0
  - res_src=0, res_src_vld=0, blk_cnt=0, err_underflow=0
  - state=IDLE, last=NREQ-1 (so requester 0 wins first), FIFO empty
- Data path is combinational mux from req_* to arb_*; no added beat latency.
- Grant latency: a request seen in IDLE at cycle t gives BUSY and forwarding at t+1.
- Block overhead: one IDLE bubble cycle after each end beat. Back-to-back blocks are therefore spaced by one cycle.
- res_src_vld rises the cycle after the push. It falls the cycle after the pop of the last entry.
- Reset mid-block: the partial block is abandoned. No tag is pushed. Requesters observe ready=0 from the reset cycle onward.
- Single-beat block (dvld & end on the first BUSY beat) is legal: push occurs that cycle.

## Test plan
- Single requester: reset, then requester 1 sends 3 beats with end on beat 3 and scanner always ready → arb_dvld_scn rises 1 cycle after req_dvld. 3 beats forwarded bit-exact. blk_cnt=1. res_src=1, res_src_vld=1.
- Round-robin: all 4 requesters hold 2-beat blocks continuously → grant order 0,1,2,3,0. One idle cycle between blocks. Non-granted arb_rdy_req stays 0.
- Backpressure: scn_rdy_arb toggles every cycle mid-block → no beat duplicated or lost. The grant holds until the end beat transfers.
- FIFO full: DEPTH=4, 4 blocks forwarded, no result completions → 5th requester stays unserved. Pulse one result completion → head popped, res_src advances, 5th block granted the next IDLE cycle.
- Simultaneous push and pop on the same cycle with 2 entries → occupancy stays 2 and order is preserved. Then a result completion with the FIFO empty → err_underflow=1 and stays set.
- Reset asserted on beat 2 of a 4-beat block → next cycle all outputs are at reset values and blk_cnt=0. A new request afterwards is granted to requester 0 first.

Source files
------------

// File: rtl/scan_arbiter.sv
// Round-robin block arbiter in front of the shared pattern scanner. It forwards whole
// blocks and records each block's source in an in-order tag FIFO for result attribution.
module scan_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4,
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_dvld,
  input  logic [8*NREQ-1:0]   req_cmd,
  input  logic [24*NREQ-1:0]  req_id,
  input  logic [32*NREQ-1:0]  req_poff,
  input  logic [256*NREQ-1:0] req_data,
  input  logic [32*NREQ-1:0]  req_bvld,
  input  logic [NREQ-1:0]     req_end,
  output logic [NREQ-1:0]     arb_rdy_req,
  output logic                arb_dvld_scn,
  output logic [7:0]          arb_cmd_scn,
  output logic [23:0]         arb_id_scn,
  output logic [31:0]         arb_poff_scn,
  output logic [255:0]        arb_data_scn,
  output logic [31:0]         arb_bvld_scn,
  output logic                arb_end_scn,
  input  logic                scn_rdy_arb,
  input  logic                scn_dvld_clt,
  input  logic                scn_end_clt,
  input  logic                clt_rdy_scn,
  output logic [GW-1:0]       res_src,
  output logic                res_src_vld,
  output logic [31:0]         blk_cnt,
  output logic                err_underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        r_state, w_next_state;
  logic [GW-1:0] r_gnt, r_last, w_pick;
  logic          w_pick_vld;

  logic [GW-1:0] r_fifo [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_occ;
  logic          w_full, w_empty, w_push, w_pop, w_done;

  logic [31:0]   r_blk_cnt;
  logic          r_err;

  logic          w_fwd, w_dvld_g, w_end_g, w_xfer_end;
  logic [7:0]    w_cmd;
  logic [23:0]   w_id;
  logic [31:0]   w_poff, w_bvld;
  logic [255:0]  w_data;

  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == (AW+1)'(DEPTH));
  assign w_done  = scn_dvld_clt & scn_end_clt & clt_rdy_scn;
  assign w_pop   = w_done & ~w_empty;
  assign w_fwd   = (r_state == BUSY) & ~reset;

  // Search starts one past the last block's owner, wrapping, so every requester is reached.
  always_comb begin
    int unsigned idx;
    w_pick     = '0;
    w_pick_vld = 1'b0;
    idx        = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (int'(r_last) + k) % NREQ;
      if (!w_pick_vld && req_dvld[GW'(idx)]) begin
        w_pick     = GW'(idx);
        w_pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_dvld_g = 1'b0;
    w_end_g  = 1'b0;
    w_cmd    = '0;
    w_id     = '0;
    w_poff   = '0;
    w_data   = '0;
    w_bvld   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_gnt == GW'(i)) begin
        w_dvld_g = req_dvld[i];
        w_end_g  = req_end[i];
        w_cmd    = req_cmd[8*i +: 8];
        w_id     = req_id[24*i +: 24];
        w_poff   = req_poff[32*i +: 32];
        w_data   = req_data[256*i +: 256];
        w_bvld   = req_bvld[32*i +: 32];
      end
    end
  end

  assign w_xfer_end = w_fwd & w_dvld_g & scn_rdy_arb & w_end_g;
  assign w_push     = w_xfer_end;

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (w_pick_vld && !w_full) w_next_state = BUSY;
      BUSY: if (w_xfer_end) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    arb_rdy_req  = '0;
    arb_dvld_scn = 1'b0;
    arb_cmd_scn  = '0;
    arb_id_scn   = '0;
    arb_poff_scn = '0;
    arb_data_scn = '0;
    arb_bvld_scn = '0;
    arb_end_scn  = 1'b0;
    if (w_fwd) begin
      arb_rdy_req[r_gnt] = scn_rdy_arb;
      arb_dvld_scn       = w_dvld_g;
      arb_cmd_scn        = w_cmd;
      arb_id_scn         = w_id;
      arb_poff_scn       = w_poff;
      arb_data_scn       = w_data;
      arb_bvld_scn       = w_bvld;
      arb_end_scn        = w_end_g;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_last    <= GW'(NREQ - 1);
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_occ     <= '0;
      r_blk_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && w_next_state == BUSY) r_gnt <= w_pick;
      if (w_push) begin
        r_wptr    <= r_wptr + 1'b1;
        r_last    <= r_gnt;
        r_blk_cnt <= r_blk_cnt + 32'd1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      if (w_done && w_empty) r_err <= 1'b1;
    end
  end

  // Tag storage needs no reset: occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_fifo[r_wptr] <= r_gnt;
  end

  assign res_src       = w_empty ? '0 : r_fifo[r_rptr];
  assign res_src_vld   = ~w_empty;
  assign blk_cnt       = r_blk_cnt;
  assign err_underflow = r_err;

endmodule

// File: tb/tb_scan_arbiter.sv
// Bench for scan_arbiter: per-requester block drivers, a beat scoreboard on the scanner
// side and a tag-queue model for res_src, driven by a vector table plus corner sequences.
module tb_scan_arbiter;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req_dvld, req_end, arb_rdy_req;
  logic [31:0]   req_cmd;
  logic [95:0]   req_id;
  logic [127:0]  req_poff, req_bvld;
  logic [1023:0] req_data;
  logic          arb_dvld_scn, arb_end_scn, scn_rdy_arb, scn_dvld_clt, scn_end_clt, clt_rdy_scn;
  logic [7:0]    arb_cmd_scn;
  logic [23:0]   arb_id_scn;
  logic [31:0]   arb_poff_scn, arb_bvld_scn, blk_cnt;
  logic [255:0]  arb_data_scn;
  logic [1:0]    res_src;
  logic          res_src_vld, err_underflow;

  scan_arbiter #(.NREQ(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .req_dvld(req_dvld), .req_cmd(req_cmd), .req_id(req_id), .req_poff(req_poff),
    .req_data(req_data), .req_bvld(req_bvld), .req_end(req_end),
    .arb_rdy_req(arb_rdy_req), .arb_dvld_scn(arb_dvld_scn), .arb_cmd_scn(arb_cmd_scn),
    .arb_id_scn(arb_id_scn), .arb_poff_scn(arb_poff_scn), .arb_data_scn(arb_data_scn),
    .arb_bvld_scn(arb_bvld_scn), .arb_end_scn(arb_end_scn), .scn_rdy_arb(scn_rdy_arb),
    .scn_dvld_clt(scn_dvld_clt), .scn_end_clt(scn_end_clt), .clt_rdy_scn(clt_rdy_scn),
    .res_src(res_src), .res_src_vld(res_src_vld), .blk_cnt(blk_cnt),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned  src;
    logic [7:0]   cmd;
    logic [23:0]  id;
    logic [31:0]  poff;
    logic [255:0] data;
    logic [31:0]  bvld;
    logic         endb;
  } beat_t;

  typedef struct {
    logic [7:0]  blk;     // blocks per requester, 2 bits each
    int unsigned len;
    logic [15:0] order;   // expected grant order, 2 bits per entry
    int unsigned norder;
    bit          tog;
    bit          aclt;
  } vec_t;

  beat_t       sbq[$];
  int          tagq[$];
  logic [31:0] m_blk;
  bit          m_err, exp_bubble;
  int unsigned d_blk[4], d_len[4], d_beat[4], d_bn[4], e_bn[4];
  bit          tog, aclt, man_clt, clt_on_end, rdy_phase, chk_en;
  int          cyc_num, first_fwd;
  int          n_cmp, n_bad;

  function automatic beat_t gen(int unsigned i, int unsigned bn, int unsigned b, int unsigned len);
    beat_t t;
    t.src  = i;
    t.cmd  = 8'((i << 4) | b);
    t.id   = 24'((i << 16) | (bn << 8) | b);
    t.poff = 32'hC0DE_0000 ^ 32'((bn << 8) | (i << 4) | b);
    for (int k = 0; k < 8; k++) t.data[32*k +: 32] = t.poff + 32'(k * 4099);
    t.bvld = ~t.poff;
    t.endb = (b == len - 1);
    return t;
  endfunction

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic apply_drv();
    bit c;
    for (int i = 0; i < 4; i++) begin
      beat_t t;
      t = gen(i, d_bn[i], d_beat[i], d_len[i]);
      req_dvld[i]            = (d_blk[i] != 0);
      req_end[i]             = t.endb;
      req_cmd[8*i +: 8]      = t.cmd;
      req_id[24*i +: 24]     = t.id;
      req_poff[32*i +: 32]   = t.poff;
      req_data[256*i +: 256] = t.data;
      req_bvld[32*i +: 32]   = t.bvld;
    end
    rdy_phase   = !rdy_phase;
    scn_rdy_arb = tog ? rdy_phase : 1'b1;
    c = man_clt || (aclt && tagq.size() != 0);
    scn_dvld_clt = c;
    scn_end_clt  = c;
    clt_rdy_scn  = c;
  endtask

  function automatic bit drv_busy();
    for (int i = 0; i < 4; i++) if (d_blk[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cyc();
    bit    comp;
    int    push_src;
    beat_t e;
    #1;
    if (clt_on_end) begin
      scn_dvld_clt = arb_dvld_scn & arb_end_scn & scn_rdy_arb;
      scn_end_clt  = scn_dvld_clt;
      clt_rdy_scn  = scn_dvld_clt;
      #1;
    end
    comp     = scn_dvld_clt & scn_end_clt & clt_rdy_scn;
    push_src = -1;
    if (chk_en) begin
      chk("res_src_vld", res_src_vld, tagq.size() != 0);
      chk("res_src", res_src, (tagq.size() != 0) ? tagq[0] : 0);
      chk("blk_cnt", blk_cnt, m_blk);
      chk("err_underflow", err_underflow, m_err);
      if (exp_bubble) chk("bubble", {arb_dvld_scn, arb_rdy_req}, 0);
      exp_bubble = 1'b0;
      if (arb_rdy_req != 0)
        chk("rdy_grant", arb_rdy_req, (sbq.size() != 0) ? (1 << sbq[0].src) : 0);
      if (arb_dvld_scn && scn_rdy_arb) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_beat: got beat id %0h expected none", arb_id_scn);
        end else begin
          e = sbq.pop_front();
          if (first_fwd < 0) first_fwd = cyc_num;
          chk("cmd", arb_cmd_scn, e.cmd);
          chk("id", arb_id_scn, e.id);
          chk("poff", arb_poff_scn, e.poff);
          chk("data", arb_data_scn, e.data);
          chk("bvld", arb_bvld_scn, e.bvld);
          chk("end", arb_end_scn, e.endb);
          if (e.endb) begin
            push_src   = int'(e.src);
            exp_bubble = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (req_dvld[i] && arb_rdy_req[i]) begin
        if (d_beat[i] == d_len[i] - 1) begin
          d_beat[i] = 0;
          d_blk[i]--;
          d_bn[i]++;
        end else d_beat[i]++;
      end
    end
    @(posedge clk);
    if (reset) begin
      sbq.delete();
      tagq.delete();
      m_blk = '0;
      m_err = 1'b0;
      exp_bubble = 1'b0;
      for (int i = 0; i < 4; i++) begin
        d_blk[i]  = 0;
        d_beat[i] = 0;
        e_bn[i]   = d_bn[i];
      end
    end else begin
      if (comp) begin
        if (tagq.size() != 0) void'(tagq.pop_front());
        else m_err = 1'b1;
      end
      if (push_src >= 0) begin
        tagq.push_back(push_src);
        m_blk++;
      end
    end
    #2;
    apply_drv();
    cyc_num++;
  endtask

  task automatic load(int unsigned i, int unsigned n, int unsigned len);
    d_blk[i]  = n;
    d_len[i]  = len;
    d_beat[i] = 0;
  endtask

  task automatic expect_block(int unsigned src, int unsigned len);
    for (int unsigned b = 0; b < len; b++) sbq.push_back(gen(src, e_bn[src], b, len));
    e_bn[src]++;
  endtask

  task automatic run_until_done(string nm, int max);
    int n = 0;
    while ((sbq.size() != 0 || drv_busy()) && n < max) begin
      cyc();
      n++;
    end
    chk({nm, "_pending"}, sbq.size(), 0);
  endtask

  task automatic drain();
    int n = 0;
    aclt = 1'b1;
    apply_drv();
    while (tagq.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    aclt = 1'b0;
    apply_drv();
    chk("drain_pending", tagq.size(), 0);
  endtask

  task automatic pulse_clt();
    man_clt = 1'b1;
    apply_drv();
    man_clt = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply_drv();
    cyc();
    reset = 1'b0;
  endtask

  vec_t vt[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'h56, 2, 16'h00E4, 5, 1'b0, 1'b1};  // 0,1,2,3,0 continuous
    vt[1] = '{8'h44, 3, 16'h000D, 2, 1'b1, 1'b0};  // 1,3 with backpressure
    vt[2] = '{8'h11, 1, 16'h0008, 2, 1'b0, 1'b0};  // 0,2 single-beat blocks
    vt[3] = '{8'h54, 2, 16'h0027, 3, 1'b1, 1'b1};  // 3,1,2 wrap from last=2
    vt[4] = '{8'h02, 4, 16'h0000, 2, 1'b0, 1'b0};  // 0,0 same requester twice

    n_cmp = 0; n_bad = 0; m_blk = '0; m_err = 1'b0; exp_bubble = 1'b0;
    tog = 0; aclt = 0; man_clt = 0; clt_on_end = 0; rdy_phase = 0; chk_en = 0;
    cyc_num = 0; first_fwd = -1;
    for (int i = 0; i < 4; i++) begin
      d_blk[i] = 0; d_len[i] = 0; d_beat[i] = 0; d_bn[i] = 0; e_bn[i] = 0;
    end
    reset = 1'b1;
    apply_drv();
    cyc();
    cyc();
    reset = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_dvld", arb_dvld_scn, 0);
    chk("rst_rdy", arb_rdy_req, 0);
    chk("rst_fields", {arb_cmd_scn, arb_id_scn, arb_poff_scn, arb_bvld_scn, arb_end_scn}, 0);
    chk("rst_data", arb_data_scn, 0);
    chk("rst_res", {res_src, res_src_vld, err_underflow}, 0);
    chk("rst_blk_cnt", blk_cnt, 0);

    // Single requester 1, three beats, grant one cycle after the request is seen.
    load(1, 1, 3);
    expect_block(1, 3);
    apply_drv();
    #1;
    chk("lat_idle", arb_dvld_scn, 0);
    cyc_num = 0;
    first_fwd = -1;
    run_until_done("single", 20);
    chk("grant_latency", first_fwd, 1);
    #1;
    chk("single_blk_cnt", blk_cnt, 1);
    chk("single_res_src", res_src, 1);
    chk("single_res_vld", res_src_vld, 1);

    do_reset();
    for (int v = 0; v < 5; v++) begin
      drain();
      tog  = vt[v].tog;
      aclt = vt[v].aclt;
      for (int i = 0; i < 4; i++) load(i, vt[v].blk[2*i +: 2], vt[v].len);
      for (int k = 0; k < int'(vt[v].norder); k++) expect_block(vt[v].order[2*k +: 2], vt[v].len);
      apply_drv();
      run_until_done($sformatf("vec%0d", v), 200);
      tog  = 1'b0;
      aclt = 1'b0;
    end

    // Tag FIFO full: the fifth block waits until one result completes.
    drain();
    load(0, 1, 1); load(1, 2, 1); load(2, 1, 1); load(3, 1, 1);
    expect_block(1, 1); expect_block(2, 1); expect_block(3, 1);
    expect_block(0, 1); expect_block(1, 1);
    apply_drv();
    for (int n = 0; n < 20; n++) cyc();
    chk("full_hold", sbq.size(), 1);
    #1;
    chk("full_no_fwd", arb_dvld_scn, 0);
    pulse_clt();
    #1;
    chk("full_idle", arb_dvld_scn, 0);
    chk("full_pop_head", res_src, 2);
    cyc();
    #1;
    chk("full_regrant", arb_dvld_scn, 1);
    run_until_done("full", 20);

    // Push and pop on the same edge with two entries held.
    drain();
    load(2, 1, 2); load(3, 1, 2);
    expect_block(2, 2); expect_block(3, 2);
    apply_drv();
    run_until_done("pp_fill", 30);
    load(0, 1, 1);
    expect_block(0, 1);
    clt_on_end = 1'b1;
    apply_drv();
    run_until_done("pp", 20);
    clt_on_end = 1'b0;
    #1;
    chk("pp_head", res_src, 3);
    chk("pp_vld", res_src_vld, 1);
    pulse_clt();
    #1;
    chk("pp_occ1", res_src_vld, 1);
    chk("pp_order", res_src, 0);
    pulse_clt();
    #1;
    chk("pp_empty", res_src_vld, 0);
    pulse_clt();
    #1;
    chk("underflow", err_underflow, 1);
    chk("underflow_fifo", res_src_vld, 0);
    for (int n = 0; n < 3; n++) cyc();
    #1;
    chk("underflow_sticky", err_underflow, 1);

    // Reset on beat 2 of a 4-beat block.
    load(2, 1, 4);
    expect_block(2, 4);
    apply_drv();
    for (int n = 0; n < 10 && d_beat[2] != 1; n++) cyc();
    chk("mid_reached", d_beat[2], 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_rdy", arb_rdy_req, 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("mid_rst_dvld", {arb_dvld_scn, arb_rdy_req}, 0);
    chk("mid_rst_fields", {arb_cmd_scn, arb_id_scn, arb_poff_scn, arb_bvld_scn, arb_end_scn}, 0);
    chk("mid_rst_res", {res_src, res_src_vld, err_underflow}, 0);
    chk("mid_rst_blk_cnt", blk_cnt, 0);
    load(0, 1, 2); load(3, 1, 2);
    expect_block(0, 2); expect_block(3, 2);
    apply_drv();
    run_until_done("post_rst", 30);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
